// File: rtl/vscpu_mem_responder.sv
// vscpu_mem_responder: arbitrates CPU word requests and host Wishbone
// requests onto one single-port SRAM with a configurable read latency.
module vscpu_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int SRAM_AW = 10,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  // CPU side
  input  logic               mem_ctrl_req,
  input  logic               mem_ctrl_we,
  input  logic [13:0]        mem_ctrl_addr,
  input  logic [31:0]        mem_ctrl_in,
  output logic [31:0]        mem_ctrl_out,
  output logic               mem_ctrl_vld,
  // Host Wishbone side
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [13:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  // SRAM port
  output logic               sram_csb0,
  output logic               sram_web0,
  output logic [3:0]         sram_wmask0,
  output logic [SRAM_AW-1:0] sram_addr0,
  output logic [31:0]        sram_din0,
  input  logic [31:0]        sram_dout0,
  output logic               busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic [14:0] LP_DEPTH    = 15'(DEPTH);
  localparam logic [1:0]  LP_LAT_LAST = 2'(RD_LAT - 1);

  state_t      r_state;
  logic        r_cpu_armed;
  logic        r_host_armed;
  logic        r_host_gnt;
  logic        r_we;
  logic        r_oor;
  logic [1:0]  r_lat_cnt;

  logic        w_host_req;
  logic        w_cpu_pend;
  logic        w_host_pend;
  logic        w_sel_we;
  logic [13:0] w_sel_addr;
  logic [31:0] w_sel_din;
  logic [3:0]  w_sel_mask;
  logic        w_sel_oor;

  assign w_host_req  = wb_cyc_i & wb_stb_i;
  assign w_cpu_pend  = mem_ctrl_req & r_cpu_armed;
  assign w_host_pend = w_host_req & r_host_armed;

  // Host has priority, so the selected request is the host one whenever it is pending
  assign w_sel_we   = w_host_pend ? wb_we_i  : mem_ctrl_we;
  assign w_sel_addr = w_host_pend ? wb_adr_i : mem_ctrl_addr;
  assign w_sel_din  = w_host_pend ? wb_dat_i : mem_ctrl_in;
  assign w_sel_mask = w_host_pend ? wb_sel_i : 4'hF;
  assign w_sel_oor  = ({1'b0, w_sel_addr} >= LP_DEPTH);

  assign busy = (r_state != ST_IDLE);

  // Arbitration, SRAM sequencing, response pulses and re-arm tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cpu_armed  <= 1'b1;
      r_host_armed <= 1'b1;
      r_host_gnt   <= 1'b0;
      r_we         <= 1'b0;
      r_oor        <= 1'b0;
      r_lat_cnt    <= '0;
      mem_ctrl_vld <= 1'b0;
      wb_ack_o     <= 1'b0;
      mem_ctrl_out <= '0;
      wb_dat_o     <= '0;
      sram_csb0    <= 1'b1;
      sram_web0    <= 1'b1;
      sram_wmask0  <= '0;
      sram_addr0   <= '0;
      sram_din0    <= '0;
    end else begin
      mem_ctrl_vld <= 1'b0;
      wb_ack_o     <= 1'b0;
      if (!mem_ctrl_req) r_cpu_armed  <= 1'b1;
      if (!w_host_req)   r_host_armed <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_host_pend || w_cpu_pend) begin
            r_host_gnt <= w_host_pend;
            r_we       <= w_sel_we;
            r_oor      <= w_sel_oor;
            // The SRAM port registers double as the address/data latch
            if (!w_sel_oor) begin
              sram_csb0   <= 1'b0;
              sram_web0   <= ~w_sel_we;
              sram_wmask0 <= w_sel_mask;
              sram_addr0  <= w_sel_addr[SRAM_AW-1:0];
              sram_din0   <= w_sel_din;
            end
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          sram_csb0   <= 1'b1;
          sram_web0   <= 1'b1;
          sram_wmask0 <= '0;
          r_lat_cnt   <= '0;
          if (!r_oor && !r_we) begin
            r_state <= ST_WAIT;
          end else begin
            r_state <= ST_RESP;
            if (r_host_gnt) wb_ack_o     <= 1'b1;
            else            mem_ctrl_vld <= 1'b1;
            if (!r_we) begin
              if (r_host_gnt) wb_dat_o     <= '0;
              else            mem_ctrl_out <= '0;
            end
          end
        end

        ST_WAIT: begin
          if (r_lat_cnt == LP_LAT_LAST) begin
            r_state <= ST_RESP;
            if (r_host_gnt) begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= sram_dout0;
            end else begin
              mem_ctrl_vld <= 1'b1;
              mem_ctrl_out <= sram_dout0;
            end
          end else begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
          // A request already dropped by now keeps its source armed
          if (r_host_gnt) begin
            if (w_host_req) r_host_armed <= 1'b0;
          end else begin
            if (mem_ctrl_req) r_cpu_armed <= 1'b0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// Testbench for vscpu_mem_responder: behavioural SRAM macro plus a word-level
// reference memory and spec-derived latencies.
module tb_vscpu_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int SRAM_AW = 10;
  localparam int RD_LAT  = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               mem_ctrl_req, mem_ctrl_we;
  logic [13:0]        mem_ctrl_addr;
  logic [31:0]        mem_ctrl_in, mem_ctrl_out;
  logic               mem_ctrl_vld;
  logic               wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]         wb_sel_i;
  logic [13:0]        wb_adr_i;
  logic [31:0]        wb_dat_i, wb_dat_o;
  logic               wb_ack_o;
  logic               sram_csb0, sram_web0;
  logic [3:0]         sram_wmask0;
  logic [SRAM_AW-1:0] sram_addr0;
  logic [31:0]        sram_din0, sram_dout0;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  vscpu_mem_responder #(.DEPTH(DEPTH), .SRAM_AW(SRAM_AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .mem_ctrl_req(mem_ctrl_req), .mem_ctrl_we(mem_ctrl_we),
    .mem_ctrl_addr(mem_ctrl_addr), .mem_ctrl_in(mem_ctrl_in),
    .mem_ctrl_out(mem_ctrl_out), .mem_ctrl_vld(mem_ctrl_vld),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM macro model: byte-masked write, read data RD_LAT cycles after issue
  logic [31:0] sram_mem [DEPTH];
  logic [31:0] rd_pipe  [RD_LAT];
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        rd_pipe[0] <= sram_mem[sram_addr0];
      end
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_dout0 = rd_pipe[RD_LAT-1];

  // Reference memory: what every in-range word should hold
  logic [31:0] ref_mem [DEPTH];

  function automatic void ref_write(input int a, input logic [31:0] d, input logic [3:0] sel);
    if (a < DEPTH)
      for (int b = 0; b < 4; b++)
        if (sel[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] ref_read(input int a);
    return (a < DEPTH) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic int exp_lat(input logic we, input int a);
    return (we || a >= DEPTH) ? 2 : 2 + RD_LAT;
  endfunction

  // CPU access: lat is the cycle (after the sampling cycle) in which vld appears
  task automatic cpu_access(input logic we, input int addr, input logic [31:0] data,
                            output logic [31:0] rdata, output int lat, output int csb_n);
    lat = -1; csb_n = 0; rdata = 'x;
    @(negedge clk);
    mem_ctrl_req = 1'b1; mem_ctrl_we = we; mem_ctrl_addr = 14'(addr); mem_ctrl_in = data;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!sram_csb0) csb_n++;
      if (mem_ctrl_vld) begin lat = n; rdata = mem_ctrl_out; break; end
    end
    mem_ctrl_req = 1'b0;
    ref_write(addr, data, we ? 4'hF : 4'h0);
  endtask

  task automatic host_access(input logic we, input logic [3:0] sel, input int addr,
                             input logic [31:0] data, output logic [31:0] rdata,
                             output int lat, output int csb_n);
    lat = -1; csb_n = 0; rdata = 'x;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_sel_i = sel;
    wb_adr_i = 14'(addr); wb_dat_i = data;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!sram_csb0) csb_n++;
      if (wb_ack_o) begin lat = n; rdata = wb_dat_o; break; end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ref_write(addr, data, we ? sel : 4'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_ctrl_vld, wb_ack_o, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl vld/ack/busy=%b expected 000", {mem_ctrl_vld, wb_ack_o, busy});
    end
    checks++;
    if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0} !== {2'b11, 4'h0, 10'h0, 32'h0}) begin
      failures++;
      $display("FAIL reset_sram csb=%b web=%b wmask=%h addr=%h din=%h expected 1 1 0 0 0",
               sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0);
    end
    checks++;
    if ({mem_ctrl_out, wb_dat_o} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data cpu_out=%h wb_dat=%h expected 0 0", mem_ctrl_out, wb_dat_o);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_host_load_cpu_read();
    logic [31:0] rd; int lat, cs;
    host_access(1'b1, 4'hF, 5, 32'hDEADBEEF, rd, lat, cs);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL host_wr_lat got %0d expected 2", lat); end
    cpu_access(1'b0, 5, 32'h0, rd, lat, cs);
    checks++;
    if (lat !== 2 + RD_LAT) begin failures++; $display("FAIL cpu_rd_lat got %0d expected %0d", lat, 2 + RD_LAT); end
    checks++;
    if (rd !== ref_read(5)) begin failures++; $display("FAIL cpu_rd_data got %h expected %h", rd, ref_read(5)); end
    checks++;
    if (cs !== 1) begin failures++; $display("FAIL cpu_rd_csb_cycles got %0d expected 1", cs); end
  endtask

  task automatic test_byte_mask();
    logic [31:0] rd; int lat, cs;
    host_access(1'b1, 4'hF,    7, 32'h11223344, rd, lat, cs);
    host_access(1'b1, 4'b0101, 7, 32'hAABBCCDD, rd, lat, cs);
    cpu_access(1'b0, 7, 32'h0, rd, lat, cs);
    checks++;
    if (rd !== ref_read(7) || rd !== 32'h11BB33DD) begin
      failures++; $display("FAIL byte_mask got %h expected %h", rd, ref_read(7));
    end
  endtask

  task automatic test_simultaneous();
    int ack_c = -1, vld_c = -1, bad_busy = 0;
    logic [31:0] cpu_rd = 'x, wdat;
    wdat = $urandom;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
    wb_adr_i = 14'd9; wb_dat_i = wdat;
    mem_ctrl_req = 1'b1; mem_ctrl_we = 1'b0; mem_ctrl_addr = 14'd9;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      // busy drops only in the single IDLE cycle between the two transactions
      if (busy !== (ack_c < 0 || n != ack_c + 1)) bad_busy++;
      if (wb_ack_o && ack_c < 0) begin ack_c = n; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
      if (mem_ctrl_vld) begin vld_c = n; cpu_rd = mem_ctrl_out; mem_ctrl_req = 1'b0; break; end
    end
    mem_ctrl_req = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ref_write(9, wdat, 4'hF);
    checks++;
    if (ack_c !== 2) begin failures++; $display("FAIL sim_host_ack got %0d expected 2", ack_c); end
    checks++;
    if (vld_c !== 3 + 2 + RD_LAT) begin failures++; $display("FAIL sim_cpu_vld got %0d expected %0d", vld_c, 5 + RD_LAT); end
    checks++;
    if (cpu_rd !== ref_read(9)) begin failures++; $display("FAIL sim_cpu_data got %h expected %h", cpu_rd, ref_read(9)); end
    checks++;
    if (bad_busy !== 0) begin failures++; $display("FAIL sim_busy bad_cycles=%0d expected 0", bad_busy); end
  endtask

  task automatic test_held_request();
    int extra = 0, acc = 0, vlds = 0;
    @(negedge clk);
    mem_ctrl_req = 1'b1; mem_ctrl_we = 1'b0; mem_ctrl_addr = 14'd5;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mem_ctrl_vld) break;
    end
    repeat (10) begin
      @(negedge clk);
      if (mem_ctrl_vld) extra++;
      if (!sram_csb0) acc++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL held_vld got %0d extra pulses expected 0", extra); end
    checks++;
    if (acc !== 0) begin failures++; $display("FAIL held_sram got %0d accesses expected 0", acc); end
    mem_ctrl_req = 1'b0;
    @(negedge clk);
    mem_ctrl_req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (mem_ctrl_vld) vlds++;
    end
    mem_ctrl_req = 1'b0;
    checks++;
    if (vlds !== 1) begin failures++; $display("FAIL rearm_vld got %0d pulses expected 1", vlds); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, d1, d2; int lat, cs;
    d1 = $urandom; d2 = $urandom;
    cpu_access(1'b1, 1023, d1, rd, lat, cs);
    cpu_access(1'b1, 16'h3FFF, 32'hCAFEF00D, rd, lat, cs);
    checks++;
    if (lat !== 2 || cs !== 0) begin failures++; $display("FAIL oor_wr lat=%0d csb=%0d expected 2 0", lat, cs); end
    cpu_access(1'b0, 16'h3FFF, 32'h0, rd, lat, cs);
    checks++;
    if (lat !== 2 || cs !== 0 || rd !== 32'h0) begin
      failures++; $display("FAIL oor_rd lat=%0d csb=%0d data=%h expected 2 0 00000000", lat, cs, rd);
    end
    cpu_access(1'b0, 1023, 32'h0, rd, lat, cs);
    checks++;
    if (rd !== ref_read(1023)) begin failures++; $display("FAIL oor_no_alias got %h expected %h", rd, ref_read(1023)); end
    cpu_access(1'b1, 1023, d2, rd, lat, cs);
    checks++;
    if (lat !== 2 || cs !== 1) begin failures++; $display("FAIL top_wr lat=%0d csb=%0d expected 2 1", lat, cs); end
    cpu_access(1'b0, 1023, 32'h0, rd, lat, cs);
    checks++;
    if (rd !== ref_read(1023)) begin failures++; $display("FAIL top_rd got %h expected %h", rd, ref_read(1023)); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rd; int lat, cs, vlds = 0;
    @(negedge clk);
    mem_ctrl_req = 1'b1; mem_ctrl_we = 1'b0; mem_ctrl_addr = 14'd9;
    repeat (2) @(negedge clk);
    rst = 1'b1; mem_ctrl_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_ctrl_vld, wb_ack_o, busy, sram_csb0, sram_web0, sram_wmask0} !== {3'b000, 2'b11, 4'h0}) begin
      failures++; $display("FAIL midrst_ctrl vld/ack/busy/csb/web/wmask=%b expected 000110000",
                           {mem_ctrl_vld, wb_ack_o, busy, sram_csb0, sram_web0, sram_wmask0});
    end
    checks++;
    if ({sram_addr0, sram_din0, mem_ctrl_out, wb_dat_o} !== '0) begin
      failures++; $display("FAIL midrst_data addr=%h din=%h cpu_out=%h wb_dat=%h expected all 0",
                           sram_addr0, sram_din0, mem_ctrl_out, wb_dat_o);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (mem_ctrl_vld) vlds++;
    end
    checks++;
    if (vlds !== 0) begin failures++; $display("FAIL midrst_no_vld got %0d pulses expected 0", vlds); end
    cpu_access(1'b0, 9, 32'h0, rd, lat, cs);
    checks++;
    if (lat !== 2 + RD_LAT || rd !== ref_read(9)) begin
      failures++; $display("FAIL midrst_fresh lat=%0d data=%h expected %0d %h", lat, rd, 2 + RD_LAT, ref_read(9));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2; int l1, l2, cs;
    cpu_access(1'b0, 5, 32'h0, rd1, l1, cs);
    cpu_access(1'b0, 7, 32'h0, rd2, l2, cs);
    checks++;
    if (l1 !== 2 + RD_LAT || l2 !== 2 + RD_LAT) begin
      failures++; $display("FAIL b2b_lat got %0d %0d expected %0d", l1, l2, 2 + RD_LAT);
    end
    checks++;
    if (rd1 !== ref_read(5) || rd2 !== ref_read(7)) begin
      failures++; $display("FAIL b2b_data got %h %h expected %h %h", rd1, rd2, ref_read(5), ref_read(7));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_cpu, exp_wb, exp_d;
    logic cpu_known, wb_known, we, host;
    logic [3:0] sel;
    int a, lat, cs, r;
    for (int i = 0; i < 16; i++) host_access(1'b1, 4'hF, i, $urandom, rd, lat, cs);
    for (int i = 1020; i < 1024; i++) host_access(1'b1, 4'hF, i, $urandom, rd, lat, cs);
    cpu_known = 1'b0; wb_known = 1'b0; exp_cpu = '0; exp_wb = '0;
    for (int it = 0; it < 60; it++) begin
      host = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      if (r < 7)      a = $urandom_range(0, 15);
      else if (r < 9) a = $urandom_range(1020, 1023);
      else            a = $urandom_range(DEPTH, 16383);
      d     = $urandom;
      sel   = host ? 4'($urandom_range(0, 15)) : 4'hF;
      exp_d = ref_read(a);
      if (host) host_access(we, sel, a, d, rd, lat, cs);
      else      cpu_access(we, a, d, rd, lat, cs);
      checks++;
      if (lat !== exp_lat(we, a) || cs !== ((a < DEPTH) ? 1 : 0)) begin
        failures++; $display("FAIL rnd_timing it=%0d host=%0d we=%0d addr=%0d lat=%0d csb=%0d expected %0d %0d",
                             it, host, we, a, lat, cs, exp_lat(we, a), (a < DEPTH) ? 1 : 0);
      end
      if (!we) begin
        checks++;
        if (rd !== exp_d) begin
          failures++; $display("FAIL rnd_rdata it=%0d host=%0d addr=%0d got %h expected %h", it, host, a, rd, exp_d);
        end
        if (host) begin exp_wb = exp_d; wb_known = 1'b1; end
        else      begin exp_cpu = exp_d; cpu_known = 1'b1; end
      end else begin
        if (host) wb_known = 1'b0;
        else      cpu_known = 1'b0;
      end
      // The other source's data output must be untouched
      if (host && cpu_known) begin
        checks++;
        if (mem_ctrl_out !== exp_cpu) begin
          failures++; $display("FAIL rnd_cpu_hold it=%0d got %h expected %h", it, mem_ctrl_out, exp_cpu);
        end
      end
      if (!host && wb_known) begin
        checks++;
        if (wb_dat_o !== exp_wb) begin
          failures++; $display("FAIL rnd_wb_hold it=%0d got %h expected %h", it, wb_dat_o, exp_wb);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_ctrl_req = 1'b0; mem_ctrl_we = 1'b0; mem_ctrl_addr = '0; mem_ctrl_in = '0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0; wb_adr_i = '0; wb_dat_i = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    test_reset();
    test_host_load_cpu_read();
    test_byte_mask();
    test_simultaneous();
    test_held_request();
    test_out_of_range();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
